// File: rtl/ahb_input_sampler.sv
// rtl/ahb_input_sampler.sv - AHB slave sampling an async input word on a prescaled tick
// Changes of the synchronized input are queued in a FIFO and read back through DATA.
module ahb_input_sampler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic [31:0] iPort,
  output logic        IRQ
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] A_DATA    = 2'd0;
  localparam logic [1:0] A_STATUS  = 2'd1;
  localparam logic [1:0] A_CONTROL = 2'd2;
  localparam logic [1:0] A_LIVE    = 2'd3;

  logic          read_en, write_en;
  logic [1:0]    addr_q;
  logic [31:0]   sync1, sync2, last_sample;
  logic          enable, irq_en;
  logic [15:0]   period, prescale;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic addr_phase, empty, full, tick, change, pop, push_ok, ovf_set;
  logic ctrl_wr, stat_wr;
  logic unused_bits;

  assign addr_phase = HSEL & HREADY & (HTRANS != 2'b00);
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign tick       = enable & (prescale == period);
  assign change     = tick & (sync2 != last_sample);
  assign pop        = read_en & (addr_q == A_DATA) & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = change & (~full | pop);
  assign ovf_set    = change & full & ~pop;
  assign ctrl_wr    = write_en & (addr_q == A_CONTROL);
  assign stat_wr    = write_en & (addr_q == A_STATUS);

  assign HREADYOUT   = 1'b1;
  assign IRQ         = irq_en & (~empty | overflow);
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[15:3]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      read_en  <= 1'b0;
      write_en <= 1'b0;
      addr_q   <= 2'b00;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      read_en  <= addr_phase & ~HWRITE;
      write_en <= addr_phase & HWRITE;
      addr_q   <= addr_phase ? HADDR[3:2] : 2'b00;
      sync1    <= iPort;
      sync2    <= sync1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      period   <= '0;
      prescale <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= HWDATA[0];
        irq_en <= HWDATA[1];
        period <= HWDATA[31:16];
      end
      if (!enable || tick) prescale <= '0;
      else                 prescale <= prescale + 16'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_sample <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      // Re-arm the change detector on enable so the first tick does not push a stale value.
      if (ctrl_wr && HWDATA[0] && !enable) last_sample <= sync2;
      else if (change)                     last_sample <= sync2;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      if (ovf_set)                    overflow <= 1'b1;
      else if (stat_wr && HWDATA[2])  overflow <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= sync2;
  end

  always_comb begin
    HRDATA = '0;
    if (read_en) begin
      case (addr_q)
        A_DATA:    HRDATA = empty ? 32'h0 : mem[rd_ptr];
        A_STATUS:  HRDATA = {23'h0, 5'(count), 1'b0, overflow, full, empty};
        A_CONTROL: HRDATA = {period, 14'h0, irq_en, enable};
        A_LIVE:    HRDATA = sync2;
        default:   HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_input_sampler.sv
// tb/tb_ahb_input_sampler.sv - randomized bench for ahb_input_sampler with a queue-based model
module tb_ahb_input_sampler;
  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA, iPort;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HSEL, HREADYOUT, IRQ;

  int checks = 0;
  int errors = 0;

  ahb_input_sampler #(.FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .iPort(iPort), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  int          cyc = 0;
  int          drive_mode = 0;
  logic [31:0] m_s1, m_s2, m_last;
  bit          m_en, m_irq_en, m_ovf, m_rd, m_wr;
  int          m_period, m_start;
  logic [1:0]  m_addr;
  logic [31:0] m_q[$];

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_last = 0;
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_rd = 0; m_wr = 0;
    m_period = 0; m_start = 0; m_addr = 0;
    m_q.delete();
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [4:0] n;
    n = 5'(m_q.size());
    if (!m_rd) return 32'h0;
    case (m_addr)
      2'd0:    return (m_q.size() > 0) ? m_q[0] : 32'h0;
      2'd1:    return {23'h0, n, 1'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
      2'd2:    return {m_period[15:0], 14'h0, m_irq_en, m_en};
      default: return m_s2;
    endcase
  endfunction

  function automatic bit exp_irq();
    return m_irq_en && (m_q.size() != 0 || m_ovf);
  endfunction

  // Advance model and DUT by one rising edge; returns at the following falling edge.
  task automatic cycle();
    bit tick, pop, push, new_ovf, ap;
    logic [31:0] sync_now;
    if (!HRESETn) begin
      model_reset();
    end else begin
      sync_now = m_s2;
      tick = m_en && (((cyc - m_start) % (m_period + 1)) == m_period);
      pop  = m_rd && m_addr == 2'd0 && m_q.size() > 0;
      push = tick && sync_now != m_last;
      new_ovf = 0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_last = sync_now;
        if (m_q.size() < DEPTH) m_q.push_back(sync_now);
        else new_ovf = 1;
      end
      if (m_wr && m_addr == 2'd1 && HWDATA[2]) m_ovf = 0;
      if (new_ovf) m_ovf = 1;
      if (m_wr && m_addr == 2'd2) begin
        if (!m_en && HWDATA[0]) begin
          m_last  = sync_now;
          m_start = cyc + 1;
        end
        m_en = HWDATA[0]; m_irq_en = HWDATA[1]; m_period = int'(HWDATA[31:16]);
      end
      ap = HSEL && HREADY && (HTRANS != 2'b00);
      m_rd = ap && !HWRITE;
      m_wr = ap && HWRITE;
      m_addr = ap ? HADDR[3:2] : 2'd0;
      m_s2 = m_s1;
      m_s1 = iPort;
    end
    cyc++;
    @(posedge HCLK);
    @(negedge HCLK);
    if (drive_mode == 1) iPort = iPort ^ 32'h0000_000F;
    else if (drive_mode == 2) iPort = $urandom_range(0, 3);
  endtask

  task automatic bus_idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = 0; HREADY = 1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a; HREADY = 1;
    cycle();
    bus_idle();
    HWDATA = d;
    cycle();
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic rdy,
                          output logic [31:0] got, output logic [31:0] exp);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a; HREADY = rdy;
    cycle();
    got = HRDATA;
    exp = exp_rdata();
    bus_idle();
    cycle();
  endtask

  task automatic do_reset();
    HRESETn = 0;
    model_reset();
    drive_mode = 0;
    iPort = 0;
    bus_idle();
    cycle();
    cycle();
    HRESETn = 1;
    cycle();
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    HRESETn = 0;
    model_reset();
    #1;
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", HRDATA); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", IRQ); end
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b want 1", HREADYOUT); end
    @(negedge HCLK);
    cycle();
    HRESETn = 1;
    cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h1) begin errors++; $display("FAIL reset_status got %h want 00000001", got); end
    ahb_read(32'h8, 1, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_control got %h want 0", got); end
    ahb_read(32'hC, 1, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL reset_live got %h want 0", got); end
  endtask

  task automatic test_basic();
    logic [31:0] got, exp;
    do_reset();
    cycle();
    ahb_write(32'h8, 32'h0000_0003);
    iPort = 32'h55;
    repeat (5) cycle();
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL basic_irq_set got %b want 1", IRQ); end
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h10) begin errors++; $display("FAIL basic_status got %h want 00000010", got); end
    ahb_read(32'h0, 1, got, exp);
    checks++; if (got !== 32'h55) begin errors++; $display("FAIL basic_data got %h want 00000055", got); end
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h1) begin errors++; $display("FAIL basic_status_empty got %h want 00000001", got); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL basic_irq_clear got %b want 0", IRQ); end
  endtask

  task automatic test_period();
    logic [31:0] got, exp;
    do_reset();
    iPort = 32'h5;
    ahb_write(32'h8, 32'h0003_0001);
    drive_mode = 1;
    repeat (20) cycle();
    // Ticks every 4th edge always see the same phase of the toggle: exactly one push.
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h10) begin errors++; $display("FAIL period_toggle_status got %h want 00000010", got); end
    ahb_read(32'h0, 1, got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL period_toggle_data got %h want %h", got, exp); end
    repeat (12) cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h1) begin errors++; $display("FAIL period_no_repush got %h want 00000001", got); end
    drive_mode = 2;
    repeat (16) cycle();
    drive_mode = 0;
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL period_rand_status got %h want %h", got, exp); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      ahb_read(32'h0, 1, got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL period_rand_data%0d got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got, exp;
    do_reset();
    ahb_write(32'h8, 32'h0000_0001);
    for (int v = 1; v <= 5; v++) begin
      iPort = v;
      repeat (3) cycle();
    end
    cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h46) begin errors++; $display("FAIL ovf_status got %h want 00000046", got); end
    ahb_write(32'h4, 32'h4);
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h42) begin errors++; $display("FAIL ovf_cleared got %h want 00000042", got); end
    for (int v = 1; v <= 4; v++) begin
      ahb_read(32'h0, 1, got, exp);
      checks++; if (got !== 32'(v)) begin errors++; $display("FAIL ovf_order%0d got %h want %h", v, got, 32'(v)); end
    end
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h1) begin errors++; $display("FAIL ovf_drained got %h want 00000001", got); end
  endtask

  task automatic test_full_pop();
    logic [31:0] got, exp;
    do_reset();
    ahb_write(32'h8, 32'h0000_0001);
    for (int v = 32'h11; v <= 32'h14; v++) begin
      iPort = v;
      repeat (3) cycle();
    end
    repeat (2) cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h42) begin errors++; $display("FAIL fullpop_full got %h want 00000042", got); end
    iPort = 32'h15;
    cycle();
    ahb_read(32'h0, 1, got, exp);
    checks++; if (got !== 32'h11) begin errors++; $display("FAIL fullpop_oldest got %h want 00000011", got); end
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h42) begin errors++; $display("FAIL fullpop_count got %h want 00000042", got); end
    for (int v = 32'h12; v <= 32'h15; v++) begin
      ahb_read(32'h0, 1, got, exp);
      checks++; if (got !== 32'(v)) begin errors++; $display("FAIL fullpop_data got %h want %h", got, 32'(v)); end
    end
  endtask

  task automatic test_stable();
    logic [31:0] got, exp;
    do_reset();
    iPort = 32'hA5A5_A5A5;
    repeat (3) cycle();
    ahb_write(32'h8, 32'h0000_0003);
    repeat (8) cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h1) begin errors++; $display("FAIL stable_status got %h want 00000001", got); end
    ahb_read(32'hC, 1, got, exp);
    checks++; if (got !== 32'hA5A5_A5A5) begin errors++; $display("FAIL stable_live got %h want a5a5a5a5", got); end
    ahb_read(32'h0, 1, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL stable_empty_data got %h want 0", got); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL stable_irq got %b want 0", IRQ); end
  endtask

  task automatic test_reset_midfill();
    logic [31:0] got, exp;
    do_reset();
    ahb_write(32'h8, 32'h0000_0003);
    for (int v = 32'h21; v <= 32'h23; v++) begin
      iPort = v;
      repeat (3) cycle();
    end
    cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h30) begin errors++; $display("FAIL midfill_count got %h want 00000030", got); end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL midfill_irq got %b want 1", IRQ); end
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h8; HWDATA = 32'h0;
    HRESETn = 0;
    model_reset();
    #1;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL midfill_async_irq got %b want 0", IRQ); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL midfill_async_hrdata got %h want 0", HRDATA); end
    @(negedge HCLK);
    bus_idle();
    cycle();
    HRESETn = 1;
    cycle();
    ahb_read(32'h4, 1, got, exp);
    checks++; if (got !== 32'h1) begin errors++; $display("FAIL midfill_status got %h want 00000001", got); end
    ahb_read(32'h8, 1, got, exp);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL midfill_control got %h want 0", got); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL midfill_irq_after got %b want 0", IRQ); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp, ctl;
    logic [15:0] p;
    int r;
    do_reset();
    p = 16'($urandom_range(0, 3));
    ahb_write(32'h8, {p, 14'h0, 1'($urandom_range(0, 1)), 1'b1});
    drive_mode = 2;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        ahb_read({28'h0, 2'($urandom_range(0, 3)), 2'b00}, ($urandom_range(0, 9) != 0), got, exp);
        checks++; if (got !== exp) begin errors++; $display("FAIL rand_read%0d got %h want %h", i, got, exp); end
      end else if (r == 5) begin
        ahb_write(32'h4, $urandom);
      end else if (r == 6) begin
        // Period is only ever rewritten with its current value so the tick cadence stays defined.
        ctl = {p, 14'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)};
        ahb_write(32'h8, ctl);
      end else if (r == 7) begin
        ahb_write(($urandom_range(0, 1) != 0) ? 32'h0 : 32'hC, $urandom);
      end else begin
        cycle();
        checks++; if (HRDATA !== exp_rdata()) begin errors++; $display("FAIL rand_idle_hrdata%0d got %h want %h", i, HRDATA, exp_rdata()); end
      end
      checks++; if (IRQ !== exp_irq()) begin errors++; $display("FAIL rand_irq%0d got %b want %b", i, IRQ, exp_irq()); end
    end
    drive_mode = 0;
  endtask

  initial begin
    HRESETn = 0;
    iPort = 0;
    HWDATA = 0;
    HSIZE = 3'b010;
    bus_idle();
    test_reset();
    test_basic();
    test_period();
    test_overflow();
    test_full_pop();
    test_stable();
    test_reset_midfill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_input_sampler.md
AHB_INPUT_SAMPLER -- requirements
Module: ahb_input_sampler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, change-event FIFO depth; power of two, 2..16.
REQ-002 HCLK  input  1  AHB clock; all state changes on rising edge.
REQ-003 HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 HADDR  input  32  address; only bits [3:2] decoded.
REQ-005 HWDATA  input  32  write data, valid in data phase.
REQ-006 HSIZE  input  3  ignored; word transfers only.
REQ-007 HTRANS  input  2  transfer type; IDLE=2'b00 is no transfer.
REQ-008 HWRITE  input  1  1=write, 0=read.
REQ-009 HREADY  input  1  bus ready; address phase qualifier.
REQ-010 HSEL  input  1  slave select.
REQ-011 HRDATA  output  32  read data, data phase.
REQ-012 HREADYOUT  output  1  tied 1; zero wait states.
REQ-013 iPort  input  32  asynchronous external input word.
REQ-014 IRQ  output  1  level interrupt to processor.

Function
REQ-015 Address phase = HSEL & HREADY & HTRANS!=IDLE; register read_en, write_en, addr[3:2] at that edge; cleared otherwise.
REQ-016 Register map: 0x0 DATA (RO, pop), 0x4 STATUS (R/W1C), 0x8 CONTROL (RW), 0xC LIVE (RO).
REQ-017 iPort passes through a 2-flop synchronizer; sync value = second flop; LIVE returns sync value.
REQ-018 CONTROL: [0] enable, [1] irq_en, [31:16] period; other bits read 0, writes ignored.
REQ-019 Prescale counter 16-bit: held at 0 while enable=0; when enable=1 increments each cycle, at count==period asserts tick for one cycle and reloads 0; period=0 gives tick every cycle.
REQ-020 On tick, if sync value != last_sample: push sync value to FIFO, last_sample <= sync value; equal value: no push.
REQ-021 Enable 0->1 write: last_sample <= current sync value in same edge; no spurious push.
REQ-022 Push when FIFO full and no simultaneous pop: data dropped, overflow <= 1, last_sample still updated.
REQ-023 Push and pop in same cycle: both occur, count unchanged, including when full (no overflow).
REQ-024 DATA read: HRDATA = FIFO head in data phase; pop at end of data phase if not empty; empty read returns 0, no pop, no error.
REQ-025 STATUS: [0] empty, [1] full, [2] overflow (sticky), [8:4] count (0..FIFO_DEPTH); writing 1 to bit 2 clears overflow; clear loses to simultaneous new overflow.
REQ-026 Writes to DATA or LIVE ignored; reads with no pending read_en give HRDATA=0.
REQ-027 Read pointer, write pointer wrap modulo FIFO_DEPTH; count tracks occupancy exactly.
REQ-028 IRQ = irq_en & (!empty | overflow), from registered state only.
REQ-029 Disabling (enable 1->0) stops ticks; FIFO contents, overflow retained and still readable.

Reset
REQ-030 HRESETn low: synchronizer, last_sample, counter, pointers, count, CONTROL, overflow, read_en, write_en all 0; HRDATA=0, IRQ=0, HREADYOUT=1.
REQ-031 Reset asserted mid-transfer or mid-FIFO-fill discards all state; first valid transfer is the first address phase after release.

Verification
REQ-032 Write CONTROL=0x0000_0003, iPort 0->0x55 -> after 2-cycle sync + tick, STATUS=0x10 (count 1), IRQ=1; DATA read returns 0x55, then STATUS=0x01, IRQ=0.
REQ-033 CONTROL period=3, enable=1, iPort toggles every cycle -> pushes only every 4th cycle and only on value difference.
REQ-034 Fill FIFO_DEPTH=4 entries, one more change -> STATUS=0x46 (full, overflow, count 4); write STATUS=0x4 -> overflow cleared, data intact in order.
REQ-035 FIFO full, DATA read coincides with tick push -> count stays 4, no overflow, oldest popped, newest stored.
REQ-036 Enable with iPort stable at 0xA5A5_A5A5 -> no push; LIVE reads 0xA5A5_A5A5; DATA read on empty returns 0.
REQ-037 Assert HRESETn mid-fill with 3 entries -> STATUS=0x01, CONTROL=0, IRQ=0 after release.
